ipod_flash_reader: RTL
======================

// Module: ipod_flash_reader
// PURPOSE
//  Downstream consumer of the keyboard controller's restart/pause/direction controls.
//  Reads 32-bit words from flash over an Avalon-MM read master.
//  Splits each word into two 16-bit samples and emits the upper byte of each, one
//  sample per sample_tick, to the audio DAC path.
// PARAMETERS
//  ADDR_W    23         flash word-address width
//  ADDR_MAX  23'h7FFFF  last word address of the song; the address wraps here
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       asynchronous, active-low reset
//  sample_tick              in   1       1-cycle strobe at the sample rate, already synchronous to clk
//  restart                  in   1       level; restart song from the start point for the current direction
//  pause                    in   1       1 = hold playback (sample ticks are ignored)
//  direction                in   1       1 = forward, 0 = backward
//  flash_mem_read           out  1       Avalon read request
//  flash_mem_address        out  ADDR_W  word address
//  flash_mem_byteenable     out  4       constant 4'hF
//  flash_mem_waitrequest    in   1       Avalon waitrequest
//  flash_mem_readdata       in   32      read data
//  flash_mem_readdatavalid  in   1       read data valid
//  audio_out                out  8       current sample (signed byte)
//  audio_valid              out  1       1-cycle pulse when audio_out updates
// BEHAVIOUR
//  Reset values (async, reset_n=0):
//   - state=IDLE, address=0, read=0, audio_out=0, audio_valid=0, word latch=0
//  FSM:
//   - IDLE: on sample_tick && !pause -> REQ. A tick arriving while paused is dropped, not queued.
//   - REQ: flash_mem_read=1, address stable.
//     - Stay while waitrequest=1; read and address must not change.
//     - waitrequest=0 -> WAIT_DATA, read=0 on the next cycle.
//   - WAIT_DATA: on readdatavalid, latch readdata, capture dir_w=direction -> OUT_FIRST.
//   - OUT_FIRST: audio_out <= dir_w ? word[15:8] : word[31:24]; audio_valid=1 for 1 cycle -> WAIT_TICK.
//   - WAIT_TICK: on sample_tick && !pause -> OUT_SECOND.
//   - OUT_SECOND: audio_out <= dir_w ? word[31:24] : word[15:8]; audio_valid=1 -> ADVANCE.
//   - ADVANCE: uses current direction.
//     - 1: address = (address==ADDR_MAX) ? 0 : address+1.
//     - 0: address = (address==0) ? ADDR_MAX : address-1.
//     - -> IDLE.
//  Latency:
//   - read asserted the cycle after the accepted tick.
//   - audio_valid asserted the cycle after readdatavalid.
//   - Second sample: audio_valid the cycle after its accepted tick.
//  Restart:
//   - In IDLE/WAIT_TICK/OUT_*/ADVANCE: the next state is IDLE, address = direction ? 0 : ADDR_MAX,
//     audio_out holds, and no audio_valid is issued that cycle.
//   - In REQ/WAIT_DATA: set restart_pend. The bus transaction completes; the returned data is
//     discarded (no audio_valid). Then address = start point for the current direction
//     (direction ? 0 : ADDR_MAX), go to IDLE, clear restart_pend.
//   - While restart stays high, the FSM stays in IDLE with the address held at the start point.
//  Pause:
//   - Only gates tick acceptance.
//   - An in-flight bus read and its OUT_FIRST still complete.
//   - audio_out holds its last value.
//  Direction change mid-word: the half order stays as captured in dir_w; the address step uses
//  the new value.
//  readdatavalid outside WAIT_DATA is ignored. At most one read is outstanding.
// TESTING
//  1. Forward, zero wait, 1-cycle data latency; word 0 = 32'hA1B2C3D4, tick, tick
//     -> read@0; audio 8'hC3 then 8'hA1; address becomes 1.
//  2. Backward from address 0, same word
//     -> audio 8'hA1 then 8'hC3; address wraps to ADDR_MAX.
//  3. Forward at ADDR_MAX
//     -> after the second sample, address = 0 and the next read is @0.
//  4. waitrequest high for 5 cycles during REQ
//     -> read and address stable for all 5 cycles; exactly 1 accepted read.
//  5. pause=1, 10 ticks
//     -> no read, no audio_valid; pause=0, then tick -> read issued the next cycle.
//  6. restart pulse while in WAIT_DATA
//     -> data discarded, no audio_valid, address = 0 (direction=1), state IDLE.
//     Repeat with reset_n pulsed low mid-REQ -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ipod_flash_reader_if.sv
// ----------------------------------------------------------------------------
// ipod_flash_reader_if
// Avalon-MM read-master bundle between the flash reader and the flash
// controller.
//   flash_mem_read           master -> slave  read request
//   flash_mem_address        master -> slave  word address (ADDR_W bits)
//   flash_mem_byteenable     master -> slave  byte enables (always all set)
//   flash_mem_waitrequest    slave  -> master request not yet accepted
//   flash_mem_readdata       slave  -> master 32-bit read data
//   flash_mem_readdatavalid  slave  -> master read data strobe
// ----------------------------------------------------------------------------
interface ipod_flash_reader_if #(
    parameter int ADDR_W = 23
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        output flash_mem_byteenable,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        input  flash_mem_byteenable,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/ipod_flash_reader.sv
// ----------------------------------------------------------------------------
// ipod_flash_reader
// Fetches 32-bit song words from flash, one word per two sample ticks, and
// plays the upper byte of each 16-bit half to the audio DAC path. Playback
// order of the halves and the address walk follow the direction control;
// restart jumps back to the start point of the current direction, pause
// gates tick acceptance only.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sample_tick  1-cycle strobe at the sample rate (synchronous to clk)
//   restart      level: return to song start for the current direction
//   pause        1 = ignore sample ticks
//   direction    1 = forward, 0 = backward
//   flash        Avalon-MM read master (ipod_flash_reader_if.master)
//   audio_out    current sample byte
//   audio_valid  1-cycle pulse when audio_out takes a new sample
// ----------------------------------------------------------------------------
module ipod_flash_reader #(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'('h7FFFF)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic                       restart,
    input  logic                       pause,
    input  logic                       direction,
    ipod_flash_reader_if.master        flash,
    output logic [7:0]                 audio_out,
    output logic                       audio_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_OUT_FIRST,
        S_WAIT_TICK,
        S_OUT_SECOND,
        S_ADVANCE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              dir_w_q, dir_w_d;
    logic              restart_pend_q, restart_pend_d;
    logic [7:0]        audio_q, audio_d;

    logic              tick_ok;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] addr_fwd;
    logic [ADDR_W-1:0] addr_bwd;
    logic [7:0]        hi_byte;
    logic [7:0]        lo_byte;

    assign tick_ok    = sample_tick && !pause;
    assign start_addr = direction ? '0 : ADDR_MAX;
    assign addr_fwd   = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
    assign addr_bwd   = (addr_q == '0) ? ADDR_MAX : addr_q - 1'b1;
    assign hi_byte    = word_q[31:24];
    assign lo_byte    = word_q[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            word_q         <= '0;
            dir_w_q        <= 1'b0;
            restart_pend_q <= 1'b0;
            audio_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            dir_w_q        <= dir_w_d;
            restart_pend_q <= restart_pend_d;
            audio_q        <= audio_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        word_d         = word_q;
        dir_w_d        = dir_w_q;
        restart_pend_d = restart_pend_q;
        audio_d        = audio_q;
        audio_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Held restart pins the address at the start point.
                if (restart) begin
                    addr_d = start_addr;
                end else if (tick_ok) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A bus request cannot be withdrawn, so restart is deferred.
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (!flash.flash_mem_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (flash.flash_mem_readdatavalid) begin
                    if (restart_pend_q || restart) begin
                        // Data of an aborted fetch is dropped.
                        addr_d         = start_addr;
                        restart_pend_d = 1'b0;
                        state_d        = S_IDLE;
                    end else begin
                        word_d  = flash.flash_mem_readdata;
                        dir_w_d = direction;
                        state_d = S_OUT_FIRST;
                    end
                end else if (restart) begin
                    restart_pend_d = 1'b1;
                end
            end
            S_OUT_FIRST: begin
                if (restart) begin
                    addr_d  = start_addr;
                    state_d = S_IDLE;
                end else begin
                    audio_d     = dir_w_q ? lo_byte : hi_byte;
                    audio_valid = 1'b1;
                    state_d     = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (restart) begin
                    addr_d  = start_addr;
                    state_d = S_IDLE;
                end else if (tick_ok) begin
                    state_d = S_OUT_SECOND;
                end
            end
            S_OUT_SECOND: begin
                if (restart) begin
                    addr_d  = start_addr;
                    state_d = S_IDLE;
                end else begin
                    audio_d     = dir_w_q ? hi_byte : lo_byte;
                    audio_valid = 1'b1;
                    state_d     = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                // Step uses the live direction, not the one captured with the word.
                if (restart) begin
                    addr_d = start_addr;
                end else begin
                    addr_d = direction ? addr_fwd : addr_bwd;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // audio_d already defaults to the held sample, so it doubles as the
    // output: the new byte appears in the same cycle as its valid pulse.
    assign audio_out                  = audio_d;
    assign flash.flash_mem_read       = (state_q == S_REQ);
    assign flash.flash_mem_address    = addr_q;
    assign flash.flash_mem_byteenable = 4'hF;

endmodule
